// File: rtl/turbo_pkg.sv
// Shared turbo-code definitions: block-length limits, constituent code
// polynomials, encoder FSM states, the RSC trellis step and BPSK mapping.
package turbo_pkg;

    localparam logic [15:0] K_MIN = 16'd40;
    localparam logic [15:0] K_MAX = 16'd6144;

    // Coefficients written D^0..D^3 from MSB to LSB: 13 octal and 15 octal.
    localparam logic [3:0] G0 = 4'b1011;
    localparam logic [3:0] G1 = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } enc_state_e;

    // Result of one trellis step; next_state is {s2, s1, s0}.
    typedef struct packed {
        logic       a;
        logic       z;
        logic [2:0] next_state;
    } rsc_step_t;

    // One RSC trellis step. state is {s2, s1, s0}; s0 is the D^1 tap.
    function automatic rsc_step_t rsc_step(input logic u, input logic [2:0] state);
        rsc_step_t r;
        r.a = u ^ (G0[2] & state[0]) ^ (G0[1] & state[1]) ^ (G0[0] & state[2]);
        r.z = (G1[3] & r.a) ^ (G1[2] & state[0]) ^ (G1[1] & state[1]) ^ (G1[0] & state[2]);
        r.next_state = {state[1], state[0], r.a};
        return r;
    endfunction

    // BPSK mapping: 0 -> +amp, 1 -> -amp.
    function automatic logic signed [15:0] bpsk(input logic b, input logic signed [15:0] amp);
        logic signed [15:0] r;
        if (b) begin
            r = -amp;
        end else begin
            r = amp;
        end
        return r;
    endfunction

endpackage

// File: rtl/rsc_encoder.sv
// LTE turbo constituent (RSC) encoder. Emits x/z pairs for every accepted
// information bit followed by three termination steps, BPSK-mapped into the
// interleaved stream the SISO decoder consumes.
module rsc_encoder
    import turbo_pkg::*;
#(
    parameter logic signed [15:0] AMP = 16'sd64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        blklen,
    input  logic               valid_blklen,
    input  logic               in,
    input  logic               valid_in,
    output logic               ready,
    output logic signed [15:0] out,
    output logic               valid_out,
    output logic               out_parity,
    output logic               out_last,
    output logic               blk_err
);

    enc_state_e         state_r;
    enc_state_e         state_nxt_s;
    logic               phase_r;
    logic               phase_nxt_s;
    logic [2:0]         trellis_r;
    logic [2:0]         trellis_nxt_s;
    logic               z_r;
    logic               z_nxt_s;
    logic [12:0]        cnt_r;
    logic [12:0]        cnt_nxt_s;
    logic [12:0]        k_last_r;
    logic [12:0]        k_last_nxt_s;
    logic [2:0]         tail_cnt_r;
    logic [2:0]         tail_cnt_nxt_s;

    logic signed [15:0] out_r;
    logic signed [15:0] out_s;
    logic               valid_out_r;
    logic               valid_out_s;
    logic               parity_r;
    logic               parity_s;
    logic               last_r;
    logic               last_s;
    logic               err_r;
    logic               err_s;

    logic               blklen_ok_s;
    logic               accept_s;
    logic               step_u_s;
    rsc_step_t          step_s;

    assign blklen_ok_s = (blklen >= K_MIN) && (blklen <= K_MAX);
    assign ready       = (state_r == ST_DATA) && (phase_r == 1'b0);
    assign accept_s    = ready && valid_in;

    assign out        = out_r;
    assign valid_out  = valid_out_r;
    assign out_parity = parity_r;
    assign out_last   = last_r;
    assign blk_err    = err_r;

    // Trellis input: information bit during DATA, termination bit s1^s2 during TAIL.
    always_comb begin
        step_u_s = 1'b0;
        if (state_r == ST_TAIL) begin
            step_u_s = trellis_r[1] ^ trellis_r[2];
        end else begin
            step_u_s = in;
        end
        step_s = rsc_step(step_u_s, trellis_r);
    end

    // State register plus all datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            phase_r     <= 1'b0;
            trellis_r   <= 3'd0;
            z_r         <= 1'b0;
            cnt_r       <= 13'd0;
            k_last_r    <= 13'd0;
            tail_cnt_r  <= 3'd0;
            out_r       <= 16'sd0;
            valid_out_r <= 1'b0;
            parity_r    <= 1'b0;
            last_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            phase_r     <= phase_nxt_s;
            trellis_r   <= trellis_nxt_s;
            z_r         <= z_nxt_s;
            cnt_r       <= cnt_nxt_s;
            k_last_r    <= k_last_nxt_s;
            tail_cnt_r  <= tail_cnt_nxt_s;
            out_r       <= out_s;
            valid_out_r <= valid_out_s;
            parity_r    <= parity_s;
            last_r      <= last_s;
            err_r       <= err_s;
        end
    end

    // Next-state logic for the IDLE/DATA/TAIL controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_blklen && blklen_ok_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (phase_r && (cnt_r == k_last_r)) begin
                    state_nxt_s = ST_TAIL;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_TAIL: begin
                if (tail_cnt_r == 3'd5) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_TAIL;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values; x is emitted on the step, z one cycle later.
    always_comb begin
        phase_nxt_s    = phase_r;
        trellis_nxt_s  = trellis_r;
        z_nxt_s        = z_r;
        cnt_nxt_s      = cnt_r;
        k_last_nxt_s   = k_last_r;
        tail_cnt_nxt_s = tail_cnt_r;
        out_s          = 16'sd0;
        valid_out_s    = 1'b0;
        parity_s       = 1'b0;
        last_s         = 1'b0;
        err_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid_blklen && blklen_ok_s) begin
                    k_last_nxt_s   = blklen[12:0] - 13'd1;
                    cnt_nxt_s      = 13'd0;
                    trellis_nxt_s  = 3'd0;
                    phase_nxt_s    = 1'b0;
                    tail_cnt_nxt_s = 3'd0;
                end else if (valid_blklen) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (phase_r) begin
                    // Parity is never delayed: it always follows its x directly.
                    out_s       = bpsk(z_r, AMP);
                    valid_out_s = 1'b1;
                    parity_s    = 1'b1;
                    phase_nxt_s = 1'b0;
                    if (cnt_r == k_last_r) begin
                        tail_cnt_nxt_s = 3'd0;
                    end else begin
                        cnt_nxt_s = cnt_r + 13'd1;
                    end
                end else if (accept_s) begin
                    out_s         = bpsk(in, AMP);
                    valid_out_s   = 1'b1;
                    z_nxt_s       = step_s.z;
                    trellis_nxt_s = step_s.next_state;
                    phase_nxt_s   = 1'b1;
                end else begin
                    valid_out_s = 1'b0;
                end
            end
            ST_TAIL: begin
                tail_cnt_nxt_s = tail_cnt_r + 3'd1;
                valid_out_s    = 1'b1;
                if (tail_cnt_r[0] == 1'b0) begin
                    out_s         = bpsk(step_u_s, AMP);
                    z_nxt_s       = step_s.z;
                    trellis_nxt_s = step_s.next_state;
                end else begin
                    out_s    = bpsk(z_r, AMP);
                    parity_s = 1'b1;
                    last_s   = (tail_cnt_r == 3'd5);
                end
            end
            default: begin
                phase_nxt_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rsc_encoder.sv
// Directed self-checking bench for rsc_encoder with an independent bit-level
// reference encoder.
module tb_rsc_encoder;

    logic               clk;
    logic               rst;
    logic [15:0]        blklen;
    logic               valid_blklen;
    logic               in;
    logic               valid_in;
    logic               ready;
    logic signed [15:0] out;
    logic               valid_out;
    logic               out_parity;
    logic               out_last;
    logic               blk_err;

    rsc_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .blklen       (blklen),
        .valid_blklen (valid_blklen),
        .in           (in),
        .valid_in     (valid_in),
        .ready        (ready),
        .out          (out),
        .valid_out    (valid_out),
        .out_parity   (out_parity),
        .out_last     (out_last),
        .blk_err      (blk_err)
    );

    typedef struct packed {
        logic signed [15:0] v;
        logic               p;
        logic               l;
    } samp_t;

    int    n_checks = 0;
    int    n_errors = 0;
    logic  bits [6144];
    samp_t exp_q [$];
    samp_t rec_q [$];
    samp_t first_q [$];
    logic [2:0] model_state;
    logic signed [15:0] hand_tab [10] = '{-16'sd64, -16'sd64, 16'sd64, -16'sd64, 16'sd64,
                                          -16'sd64, 16'sd64, -16'sd64, 16'sd64, 16'sd64};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [15:0] amp_of(input logic b);
        return b ? -16'sd64 : 16'sd64;
    endfunction

    // Reference encoder: g0 = 1+D^2+D^3 feedback, g1 = 1+D+D^3 parity.
    task automatic build_expected(input int k);
        logic s0, s1, s2, u, a, z;
        samp_t sx, sz;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        exp_q.delete();
        for (int i = 0; i < k + 3; i++) begin
            u = (i < k) ? bits[i] : (s1 ^ s2);
            a = u ^ s1 ^ s2;
            z = a ^ s0 ^ s2;
            s2 = s1; s1 = s0; s0 = a;
            sx.v = amp_of(u); sx.p = 1'b0; sx.l = 1'b0;
            sz.v = amp_of(z); sz.p = 1'b1; sz.l = (i == k + 2);
            exp_q.push_back(sx);
            exp_q.push_back(sz);
        end
        model_state = {s2, s1, s0};
    endtask

    task automatic run_block(input int k, input bit throttle, input bit inject, input int abort_at);
        int idx, nsamp, gaps, cyc, budget;
        bit done, acc, injd, injt;
        samp_t e;
        build_expected(k);
        rec_q.delete();
        blklen = k[15:0];
        valid_blklen = 1'b1;
        tick();
        valid_blklen = 1'b0;
        check("start_ready", ready, 1);
        idx = 0; nsamp = 0; gaps = 0; cyc = 0; done = 0; injd = 0; injt = 0;
        budget = 8 * k + 200;
        while (!done && cyc < budget) begin
            valid_in = (idx < k) && (throttle ? ($urandom_range(0, 1) == 1) : 1'b1);
            in = (idx < k) ? bits[idx] : 1'b0;
            if (inject && idx == 20 && !injd) begin
                valid_blklen = 1'b1; blklen = 16'd100; injd = 1;
            end
            if (inject && nsamp == 2 * k + 1 && !injt) begin
                valid_blklen = 1'b1; blklen = 16'd64; injt = 1;
            end
            acc = valid_in && ready;
            tick();
            cyc++;
            valid_blklen = 1'b0;
            blklen = k[15:0];
            if (acc) begin
                idx++;
                check("ready_after_accept", ready, 0);
            end
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("extra_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_value", out, e.v);
                    check("sample_parity", out_parity, e.p);
                    check("sample_last", out_last, e.l);
                end
                rec_q.push_back({out, out_parity, out_last});
                nsamp++;
                if (out_last) done = 1;
            end else if (nsamp > 0) begin
                gaps++;
            end
            if (abort_at >= 0 && acc && idx == abort_at) begin
                valid_in = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("abort_out", out, 0);
                check("abort_valid", valid_out, 0);
                check("abort_parity", out_parity, 0);
                check("abort_last", out_last, 0);
                check("abort_ready", ready, 0);
                valid_in = 1'b0;
                return;
            end
        end
        valid_in = 1'b0;
        check("block_done", done, 1);
        check("sample_count", nsamp, 2 * k + 6);
        check("model_final_state", model_state, 0);
        if (!throttle) check("contiguous_valid", gaps, 0);
    endtask

    initial begin
        rst = 1'b1; blklen = 16'd0; valid_blklen = 1'b0; in = 1'b0; valid_in = 1'b0;
        tick();
        tick();
        check("rst_out", out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_parity", out_parity, 0);
        check("rst_last", out_last, 0);
        check("rst_err", blk_err, 0);
        check("rst_ready", ready, 0);
        rst = 1'b0;
        tick();

        // K=40 all zero bits
        for (int i = 0; i < 6144; i++) bits[i] = 1'b0;
        run_block(40, 0, 0, -1);
        check("zero_count", rec_q.size(), 86);
        check("zero_last_amp", rec_q[85].v, 16'sd64);
        tick();

        // K=40 single leading one: hand-computed first ten samples
        bits[0] = 1'b1;
        run_block(40, 0, 0, -1);
        for (int i = 0; i < 10; i++) check("hand_vector", rec_q[i].v, hand_tab[i]);
        tick();

        // Illegal block lengths
        for (int j = 0; j < 2; j++) begin
            blklen = (j == 0) ? 16'd39 : 16'd6145;
            valid_blklen = 1'b1;
            tick();
            valid_blklen = 1'b0;
            check("err_pulse", blk_err, 1);
            check("err_ready", ready, 0);
            check("err_no_valid", valid_out, 0);
            tick();
            check("err_one_cycle", blk_err, 0);
            check("err_still_idle", ready, 0);
        end

        // K=6144 random bits, throttled input
        for (int i = 0; i < 6144; i++) bits[i] = $urandom_range(0, 1) == 1;
        run_block(6144, 1, 0, -1);
        tick();

        // Reset mid-block, then a clean K=512 block
        run_block(512, 0, 0, 100);
        tick();
        run_block(512, 1, 0, -1);
        tick();

        // Back-to-back K=512 blocks with identical input
        run_block(512, 0, 0, -1);
        first_q = rec_q;
        run_block(512, 0, 0, -1);
        begin
            int diffs;
            diffs = 0;
            if (rec_q.size() != first_q.size()) diffs = 1;
            else for (int i = 0; i < rec_q.size(); i++) if (rec_q[i] != first_q[i]) diffs++;
            check("back_to_back_equal", diffs, 0);
        end
        tick();

        // Start strobes during DATA and TAIL are ignored
        run_block(40, 0, 1, -1);
        tick();
        check("idle_after_inject", ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
